// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: arbitration mode codes and
// the port-index width helper.
package mem_arb_pkg;

   localparam int ARB_FIXED = 32'sd0;
   localparam int ARB_RR    = 32'sd1;

   // Bits needed to index n ports (never less than one).
   function automatic int clog2(input int n);
      int w;
      w = 32'sd1;
      while ((32'sd1 << w) < n) begin
         w = w + 32'sd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter. It searches from ptr upward with wrap in
// round-robin mode, and from index 0 in fixed-priority mode.
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int MODE      = ARB_RR,
   parameter int PW        = clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PW-1:0]        ptr,
   output logic [NUM_PORTS-1:0] grant,
   output logic [PW-1:0]        grant_idx,
   output logic                 grant_any
);

   logic [PW-1:0] eff_ptr_s;
   logic [PW-1:0] sel_s;
   int            idx_s;

   // First requester found from the effective start point wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      sel_s     = '0;
      idx_s     = 32'sd0;
      eff_ptr_s = (MODE == ARB_RR) ? ptr : '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx_s = int'(eff_ptr_s) + k;
         if (idx_s >= NUM_PORTS) begin
            idx_s = idx_s - NUM_PORTS;
         end else begin
            idx_s = idx_s;
         end
         sel_s = PW'(idx_s);
         if (!grant_any && req[sel_s]) begin
            grant[sel_s] = 1'b1;
            grant_idx    = sel_s;
            grant_any    = 1'b1;
         end else begin
            grant_any = grant_any;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter in front of the shared ideal_mem data port, with lock,
// read-return tag routing over the memory latency and saturating stall counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1,
   parameter int RR_MODE    = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                             riscv_cpu_clk,
   input  logic                             riscv_cpu_resetn,
   input  logic [NUM_PORTS-1:0]             req_valid,
   output logic [NUM_PORTS-1:0]             req_ready,
   input  logic [NUM_PORTS-1:0]             req_wr,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb,
   input  logic                             lock_en,
   input  logic [2:0]                       lock_id,
   output logic [NUM_PORTS-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic                             mem_wren,
   output logic [DATA_WIDTH/8-1:0]          mem_wstrb,
   output logic [DATA_WIDTH-1:0]            mem_wdata,
   output logic                             mem_rden,
   input  logic [DATA_WIDTH-1:0]            mem_rdata,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]   stall_cnt
);

   localparam int PW = clog2(NUM_PORTS);
   localparam int SW = DATA_WIDTH / 8;

   logic [1:0]                           rst_sync_q, rst_sync_d;
   logic                                 rst_n_int_s;
   logic [NUM_PORTS-1:0]                 elig_s, grant_s, rd_accept_s;
   logic [PW-1:0]                        grant_idx_s;
   logic                                 grant_any_s;
   logic [PW-1:0]                        rr_ptr_q, rr_ptr_d;
   logic [RD_LATENCY-1:0][NUM_PORTS-1:0] tag_q, tag_d;
   logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  stall_q, stall_d;

   // Reset asserts asynchronously but leaves the block only on a clock edge.
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   always_ff @(posedge riscv_cpu_clk or negedge riscv_cpu_resetn) begin
      if (!riscv_cpu_resetn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_n_int_s = rst_sync_q[1];

   // Grants are masked while in reset so the memory port goes quiet immediately.
   always_comb begin
      elig_s = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (req_valid[i] && rst_n_int_s && (!lock_en || (lock_id == 3'(i)))) begin
            elig_s[i] = 1'b1;
         end else begin
            elig_s[i] = 1'b0;
         end
      end
   end

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .MODE      (RR_MODE),
      .PW        (PW)
   ) u_arb (
      .req       (elig_s),
      .ptr       (rr_ptr_q),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_any (grant_any_s)
   );

   assign req_ready = grant_s;

   always_comb begin
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_wstrb   = '0;
      mem_wren    = 1'b0;
      mem_rden    = 1'b0;
      rd_accept_s = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_s[i]) begin
            mem_addr       = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata      = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            mem_wstrb      = req_wstrb[i*SW +: SW];
            mem_wren       = req_wr[i];
            mem_rden       = !req_wr[i];
            rd_accept_s[i] = !req_wr[i];
         end else begin
            rd_accept_s[i] = 1'b0;
         end
      end
   end

   // Pointer moves past the winner only when a transfer actually happens.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if ((RR_MODE == ARB_RR) && grant_any_s) begin
         if (grant_idx_s == PW'(NUM_PORTS - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx_s + PW'(1);
         end
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   always_comb begin
      tag_d    = '0;
      tag_d[0] = rd_accept_s;
      for (int s = 1; s < RD_LATENCY; s++) begin
         tag_d[s] = tag_q[s-1];
      end
   end

   assign rsp_valid = tag_q[RD_LATENCY-1];

   // The shared return bus only carries memory data when some port owns it.
   always_comb begin
      if (|tag_q[RD_LATENCY-1]) begin
         rsp_rdata = mem_rdata;
      end else begin
         rsp_rdata = '0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (req_valid[i] && !grant_s[i] && (stall_q[i] != {CNT_WIDTH{1'b1}})) begin
            stall_d[i] = stall_q[i] + CNT_WIDTH'(1);
         end else begin
            stall_d[i] = stall_q[i];
         end
      end
   end

   assign stall_cnt = stall_q;

   // Pointer, return tags and counters all clear on reset, dropping in-flight reads.
   always_ff @(posedge riscv_cpu_clk or negedge rst_n_int_s) begin
      if (!rst_n_int_s) begin
         rr_ptr_q <= '0;
         tag_q    <= '0;
         stall_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         tag_q    <= tag_d;
         stall_q  <= stall_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A is round-robin with 1-cycle memory latency,
// instance B is fixed priority with 3-cycle latency and 4-bit stall counters.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic        rstn_a, rstn_b;
   logic [1:0]  va, wra, ready_a, rspv_a;
   logic [17:0] addr_a;
   logic [63:0] wdata_a;
   logic [7:0]  wstrb_a;
   logic        lock_en_a;
   logic [2:0]  lock_id_a;
   logic [31:0] rdata_a, mwdata_a, mrdata_a;
   logic [8:0]  maddr_a;
   logic        mwren_a, mrden_a;
   logic [3:0]  mwstrb_a;
   logic [31:0] stall_a;

   logic [1:0]  vb, wrb, ready_b, rspv_b;
   logic [17:0] addr_b;
   logic [63:0] wdata_b;
   logic [7:0]  wstrb_b;
   logic        lock_en_b;
   logic [2:0]  lock_id_b;
   logic [31:0] rdata_b, mwdata_b, mrdata_b;
   logic [8:0]  maddr_b;
   logic        mwren_b, mrden_b;
   logic [3:0]  mwstrb_b;
   logic [7:0]  stall_b;

   logic [31:0] mem_a [0:511];
   logic [31:0] mem_b [0:511];
   logic [31:0] rd_b1, rd_b2;

   mem_port_arbiter #(
      .NUM_PORTS(2), .ADDR_WIDTH(9), .DATA_WIDTH(32),
      .RD_LATENCY(1), .RR_MODE(1), .CNT_WIDTH(16)
   ) dut_a (
      .riscv_cpu_clk(clk), .riscv_cpu_resetn(rstn_a),
      .req_valid(va), .req_ready(ready_a), .req_wr(wra),
      .req_addr(addr_a), .req_wdata(wdata_a), .req_wstrb(wstrb_a),
      .lock_en(lock_en_a), .lock_id(lock_id_a),
      .rsp_valid(rspv_a), .rsp_rdata(rdata_a),
      .mem_addr(maddr_a), .mem_wren(mwren_a), .mem_wstrb(mwstrb_a),
      .mem_wdata(mwdata_a), .mem_rden(mrden_a), .mem_rdata(mrdata_a),
      .stall_cnt(stall_a)
   );

   mem_port_arbiter #(
      .NUM_PORTS(2), .ADDR_WIDTH(9), .DATA_WIDTH(32),
      .RD_LATENCY(3), .RR_MODE(0), .CNT_WIDTH(4)
   ) dut_b (
      .riscv_cpu_clk(clk), .riscv_cpu_resetn(rstn_b),
      .req_valid(vb), .req_ready(ready_b), .req_wr(wrb),
      .req_addr(addr_b), .req_wdata(wdata_b), .req_wstrb(wstrb_b),
      .lock_en(lock_en_b), .lock_id(lock_id_b),
      .rsp_valid(rspv_b), .rsp_rdata(rdata_b),
      .mem_addr(maddr_b), .mem_wren(mwren_b), .mem_wstrb(mwstrb_b),
      .mem_wdata(mwdata_b), .mem_rden(mrden_b), .mem_rdata(mrdata_b),
      .stall_cnt(stall_b)
   );

   // Memory A: byte-strobed writes, read data one cycle after mem_rden.
   always @(posedge clk) begin
      if (mwren_a) begin
         for (int b = 0; b < 4; b++) begin
            if (mwstrb_a[b]) mem_a[maddr_a][b*8 +: 8] <= mwdata_a[b*8 +: 8];
         end
      end
      if (mrden_a) mrdata_a <= mem_a[maddr_a];
   end

   // Memory B: three-stage read pipeline.
   always @(posedge clk) begin
      if (mwren_b) begin
         for (int b = 0; b < 4; b++) begin
            if (mwstrb_b[b]) mem_b[maddr_b][b*8 +: 8] <= mwdata_b[b*8 +: 8];
         end
      end
      rd_b1    <= mem_b[maddr_b];
      rd_b2    <= rd_b1;
      mrdata_b <= rd_b2;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem_a[i] = 32'h0;
         mem_b[i] = 32'h0;
      end
      mem_a[1] = 32'h1111_1111;
      mem_a[2] = 32'h2222_2222;
      mem_a[5] = 32'h1234_5678;
      mem_b[1] = 32'hAAAA_0001;
      mem_b[2] = 32'hAAAA_0002;
      mem_b[3] = 32'hAAAA_0003;
      mrdata_a = 32'h0; mrdata_b = 32'h0; rd_b1 = 32'h0; rd_b2 = 32'h0;

      rstn_a = 1'b0; rstn_b = 1'b0;
      va = 2'b11; wra = 2'b00; addr_a = 18'h0; wdata_a = 64'h0; wstrb_a = 8'h0;
      lock_en_a = 1'b0; lock_id_a = 3'd0;
      vb = 2'b11; wrb = 2'b00; addr_b = 18'h0; wdata_b = 64'h0; wstrb_b = 8'h0;
      lock_en_b = 1'b0; lock_id_b = 3'd0;
      repeat (3) cyc();
      check("rst_ready_a", ready_a, 2'b00);
      check("rst_ready_b", ready_b, 2'b00);
      check("rst_rspv_a", rspv_a, 2'b00);
      check("rst_rdata_a", rdata_a, 32'h0);
      check("rst_rden_a", mrden_a, 1'b0);
      check("rst_maddr_a", maddr_a, 9'h0);
      check("rst_stall_a", stall_a, 32'h0);
      check("rst_stall_b", stall_b, 8'h0);

      va = 2'b00; vb = 2'b00;
      rstn_a = 1'b1; rstn_b = 1'b1;
      repeat (3) cyc();

      // Round robin, both ports reading
      va = 2'b11; addr_a = {9'd2, 9'd1};
      #1;
      check("rr_c0_ready", ready_a, 2'b01);
      check("rr_c0_rden", mrden_a, 1'b1);
      check("rr_c0_addr", maddr_a, 9'd1);
      check("rr_c0_rspv", rspv_a, 2'b00);
      cyc();
      check("rr_c1_ready", ready_a, 2'b10);
      check("rr_c1_addr", maddr_a, 9'd2);
      check("rr_c1_rspv", rspv_a, 2'b01);
      check("rr_c1_rdata", rdata_a, 32'h1111_1111);
      cyc();
      check("rr_c2_ready", ready_a, 2'b01);
      check("rr_c2_rspv", rspv_a, 2'b10);
      check("rr_c2_rdata", rdata_a, 32'h2222_2222);
      cyc();
      check("rr_c3_ready", ready_a, 2'b10);
      check("rr_c3_rspv", rspv_a, 2'b01);
      cyc();
      va = 2'b00;
      #1;
      check("rr_c4_rspv", rspv_a, 2'b10);
      check("rr_c4_rdata", rdata_a, 32'h2222_2222);
      check("rr_c4_ready", ready_a, 2'b00);
      check("rr_stall", stall_a, 32'h0002_0002);
      cyc();
      check("rr_c5_rspv", rspv_a, 2'b00);
      check("rr_c5_rdata", rdata_a, 32'h0);

      // Partial write from port 1, then read-back from port 0
      cyc();
      va = 2'b10; wra = 2'b10; addr_a = {9'd5, 9'd0};
      wdata_a = {32'hDEAD_BEEF, 32'h0}; wstrb_a = {4'b0011, 4'b0000};
      #1;
      check("wr_ready", ready_a, 2'b10);
      check("wr_wren", mwren_a, 1'b1);
      check("wr_rden", mrden_a, 1'b0);
      check("wr_addr", maddr_a, 9'd5);
      check("wr_wstrb", mwstrb_a, 4'b0011);
      check("wr_wdata", mwdata_a, 32'hDEAD_BEEF);
      cyc();
      va = 2'b01; wra = 2'b00; addr_a = {9'd0, 9'd5}; wstrb_a = 8'h0;
      #1;
      check("rd5_ready", ready_a, 2'b01);
      check("rd5_rden", mrden_a, 1'b1);
      check("wr_no_rsp", rspv_a, 2'b00);
      cyc();
      va = 2'b00;
      #1;
      check("rd5_rspv", rspv_a, 2'b01);
      check("rd5_rdata", rdata_a, 32'h1234_BEEF);

      // Lock to port 1, then to a nonexistent port
      cyc();
      lock_en_a = 1'b1; lock_id_a = 3'd1; va = 2'b11; addr_a = {9'd2, 9'd1};
      #1;
      check("lock1_ready", ready_a, 2'b10);
      cyc();
      lock_id_a = 3'd3;
      #1;
      check("lock3_ready", ready_a, 2'b00);
      check("lock3_rden", mrden_a, 1'b0);
      check("lock3_wren", mwren_a, 1'b0);
      check("lock3_rspv", rspv_a, 2'b10);
      check("lock3_rdata", rdata_a, 32'h2222_2222);
      cyc();
      va = 2'b00; lock_en_a = 1'b0; lock_id_a = 3'd0;
      #1;
      check("lock_end_rspv", rspv_a, 2'b00);
      check("lock_stall", stall_a, 32'h0003_0004);

      // Fixed priority with latency 3
      cyc();
      vb = 2'b11; addr_b = {9'd2, 9'd1};
      #1;
      check("fx_c0_ready", ready_b, 2'b01);
      cyc();
      check("fx_c1_ready", ready_b, 2'b01);
      cyc();
      check("fx_c2_ready", ready_b, 2'b01);
      check("fx_c2_rspv", rspv_b, 2'b00);
      cyc();
      vb = 2'b00;
      #1;
      check("fx_stall", stall_b, 8'h30);
      check("fx_c3_rspv", rspv_b, 2'b01);
      check("fx_c3_rdata", rdata_b, 32'hAAAA_0001);
      repeat (3) cyc();
      check("fx_c6_rspv", rspv_b, 2'b00);

      // Reads 0,1,0 in flight when reset hits
      cyc();
      vb = 2'b01; addr_b = {9'd0, 9'd3};
      #1;
      check("fl_c0_ready", ready_b, 2'b01);
      cyc();
      vb = 2'b10; addr_b = {9'd2, 9'd0};
      #1;
      check("fl_c1_ready", ready_b, 2'b10);
      cyc();
      vb = 2'b01; addr_b = {9'd0, 9'd1};
      #1;
      check("fl_c2_ready", ready_b, 2'b01);
      cyc();
      vb = 2'b11; rstn_b = 1'b0;
      #1;
      check("mrst_ready", ready_b, 2'b00);
      check("mrst_rspv", rspv_b, 2'b00);
      check("mrst_rdata", rdata_b, 32'h0);
      check("mrst_rden", mrden_b, 1'b0);
      check("mrst_stall", stall_b, 8'h00);
      cyc();
      vb = 2'b00;
      #1;
      check("mrst_hold_rspv", rspv_b, 2'b00);
      cyc();
      rstn_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         check("post_rst_rspv", rspv_b, 2'b00);
      end

      // Stall counter saturation
      vb = 2'b11; addr_b = 18'h0;
      #1;
      check("sat_ready", ready_b, 2'b01);
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (i == 14) check("sat_14", stall_b, 8'hE0);
      end
      vb = 2'b00;
      #1;
      check("sat_final", stall_b, 8'hF0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-port arbiter in front of the shared data port of ideal_mem.
- Replaces the fixed two-way CPU/AXI-Lite read/write mux at the CPU top.
- Losing requesters are stalled through valid/ready; contention never returns all-ones data.
- Adds fixed-priority or round-robin grant, single-port lock, pipelined read-return routing over a configurable memory read latency, and per-port stall counters.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8); port 0 is the CPU.
- ADDR_WIDTH, 9, memory word-address width.
- DATA_WIDTH, 32, data width; multiple of 8.
- RD_LATENCY, 1, cycles from mem_rden to valid mem_rdata (1..4).
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- CNT_WIDTH, 16, width of each stall counter.

Ports:
- riscv_cpu_clk  in  1  clock
- riscv_cpu_resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port request accepted this cycle
- req_wr  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_WIDTH  word address; port i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*DATA_WIDTH  write data
- req_wstrb  in  NUM_PORTS*DATA_WIDTH/8  byte-write strobes
- lock_en  in  1  restrict grants to port lock_id
- lock_id  in  3  locked port index
- rsp_valid  out  NUM_PORTS  read data valid for port i
- rsp_rdata  out  DATA_WIDTH  shared read-return bus
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wren  out  1  memory write enable
- mem_wstrb  out  DATA_WIDTH/8  memory byte strobes
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rden  out  1  memory read enable
- mem_rdata  in  DATA_WIDTH  memory read data
- stall_cnt  out  NUM_PORTS*CNT_WIDTH  per-port stall counters

Behaviour:
- Reset (async assert, sync deassert inside block):
  - req_ready, rsp_valid, mem_wren, mem_rden, mem_wstrb = 0; mem_addr, mem_wdata, rsp_rdata = 0.
  - RR pointer = 0; return pipeline cleared; stall_cnt = 0.
- Grant is combinational, at most one port per cycle.
  - Eligible ports: req_valid[i] && (!lock_en || i == lock_id).
  - RR_MODE=0: lowest eligible index wins.
  - RR_MODE=1: search starts at pointer p, then wraps (p, p+1, ..., NUM_PORTS-1, 0, ...).
- req_ready[g] = 1 only for the granted port g. The transfer occurs when valid && ready in the same cycle.
- No backpressure from memory:
  - Grant g: mem_addr/mem_wdata/mem_wstrb come from port g. mem_wren = req_wr[g]; mem_rden = !req_wr[g].
  - No grant: mem_wren = mem_rden = 0, mem_wstrb = 0.
- Pointer update (RR only): on a transfer by g, p <= (g+1) mod NUM_PORTS. Otherwise p holds.
- Read return:
  - A shift pipeline of depth RD_LATENCY carries a one-hot port tag for each accepted read.
  - rsp_valid[i] pulses exactly RD_LATENCY cycles after acceptance, with rsp_rdata = mem_rdata in that cycle.
  - rsp_rdata = 0 when no rsp_valid is set.
  - Back-to-back reads from different ports return in order, one per cycle.
- Writes produce no response. A write and a read to the same address in consecutive cycles follow memory order: the later read sees the new data.
- Lock:
  - lock_en rising mid-stream does not affect reads already in the pipeline.
  - lock_id >= NUM_PORTS with lock_en = 1: no grants.
- Stall counters: stall_cnt[i] increments every cycle in which req_valid[i] && !req_ready[i]. It saturates at all-ones and does not wrap.
- Requesters must hold req_* stable while valid && !ready. The block does not check this.
- Reset mid-operation: in-flight read tags are discarded and no rsp_valid pulses after reset.

Decomposition:
- Shared package mem_arb_pkg:
  - port-index width function clog2(NUM_PORTS).
  - mode constants ARB_FIXED = 0, ARB_RR = 1.
- Sub-module rr_arbiter: request vector + pointer in, one-hot grant out, combinational, mode-selectable.
- Return-tag pipeline and counters stay in the top of the block.

Test Plan:
- RR, NUM_PORTS=2, both ports read continuously for 4 cycles -> grants alternate 0,1,0,1; rsp_valid[0] at t+1 and t+3, rsp_valid[1] at t+2 and t+4 (RD_LATENCY=1); stall_cnt = {2,2}.
- Fixed priority, ports 0 and 1 both valid for 3 cycles -> port 0 granted every cycle; stall_cnt[1] = 3, stall_cnt[0] = 0.
- Port 1 writes 0xDEADBEEF at addr 5 with wstrb 4'b0011, then port 0 reads addr 5 (memory preloaded 0x12345678) -> rsp_rdata = 0x1234BEEF on rsp_valid[0].
- lock_en=1, lock_id=1, both ports valid -> only port 1 ready; with lock_id=3 and NUM_PORTS=2 -> no req_ready, mem_rden = mem_wren = 0.
- RD_LATENCY=3, reads accepted from ports 0,1,0 on consecutive cycles; resetn asserted low one cycle after the last acceptance -> outputs zero immediately; no rsp_valid after reset release.
- CNT_WIDTH=4, port 1 held stalled for 20 cycles -> stall_cnt[1] = 15 (saturated).
